param_systolic_array: RTL and testbench

//  Parametrised NxN output-stationary systolic matrix multiplier, C = A x B. Successor of the fixed 3x3 array:

---
 rtl/systolic_pkg.sv | 11 +
 rtl/systolic_pe.sv | 54 +++++
 rtl/param_systolic_array.sv | 159 +++++++++++++++
 tb/tb_param_systolic_array.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the parametrised output-stationary systolic array.
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    // Counter width that can hold values up to 2N-1 (beats and flush cycles share one counter).
    function automatic int cnt_w(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: forwards a right and b down through one register each,
// and accumulates the (sign- or zero-extended) product of its inputs every cycle.
module systolic_pe #(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 10,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    logic [DATA_W-1:0]   a_q, b_q;
    logic [ACC_W-1:0]    acc_q;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;

    if (SIGNED != 0) begin : g_signed
        logic signed [2*DATA_W-1:0] a_x, b_x;
        assign a_x      = (2*DATA_W)'($signed(a_in));
        assign b_x      = (2*DATA_W)'($signed(b_in));
        assign prod     = a_x * b_x;
        assign prod_ext = ACC_W'($signed(prod));
    end else begin : g_unsigned
        logic [2*DATA_W-1:0] a_x, b_x;
        assign a_x      = (2*DATA_W)'(a_in);
        assign b_x      = (2*DATA_W)'(b_in);
        assign prod     = a_x * b_x;
        assign prod_ext = ACC_W'(prod);
    end

    // clr restarts the sum with this cycle's product so no cycle of the new job is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc_q <= (clr ? '0 : acc_q) + prod_ext;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/param_systolic_array.sv
// NxN output-stationary systolic multiplier C = A x B with valid/ready operand intake,
// internal input skew and a row-serial result drain.
module param_systolic_array
    import systolic_pkg::*;
#(
    parameter int N      = 3,
    parameter int DATA_W = 4,
    parameter int ACC_W  = 2*DATA_W + $clog2(N),
    parameter int SIGNED = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N*DATA_W-1:0]     a_col_in,
    input  logic [N*DATA_W-1:0]     b_row_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic [N*ACC_W-1:0]      c_row_out,
    output logic [$clog2(N)-1:0]    row_idx,
    output logic                    valid_out,
    input  logic                    out_ready,
    output logic                    busy,
    output state_t                  state_o
);

    localparam int CNT_W = cnt_w(N);
    localparam int RW    = $clog2(N);

    // Handshakes: a beat moves when valid_in & ready_out at a rising edge; a result row
    // moves when valid_out & out_ready at a rising edge. Neither side may depend on the other.
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RW-1:0]      row_q;
    logic               ready_q, valid_q;
    logic               accept, clr;
    logic [N*DATA_W-1:0] a_inj, b_inj;

    assign accept = valid_in & ready_q;
    assign clr    = accept & (state_q == IDLE);
    assign a_inj  = accept ? a_col_in : '0;
    assign b_inj  = accept ? b_row_in : '0;

    logic [DATA_W-1:0] a_h [N][N];
    logic [DATA_W-1:0] b_v [N][N];
    logic [DATA_W-1:0] a_edge_unused [N];
    logic [DATA_W-1:0] b_edge_unused [N];
    logic [ACC_W-1:0]  acc_w [N][N];

    // Lane i of both operands is delayed i cycles so matching k-terms meet in PE(i,j).
    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_d0
            assign a_h[0][0] = a_inj[0 +: DATA_W];
            assign b_v[0][0] = b_inj[0 +: DATA_W];
        end else begin : g_dn
            logic [i*DATA_W-1:0] a_sr_q, b_sr_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_sr_q <= '0;
                    b_sr_q <= '0;
                end else begin
                    a_sr_q <= (i*DATA_W)'({a_sr_q, a_inj[i*DATA_W +: DATA_W]});
                    b_sr_q <= (i*DATA_W)'({b_sr_q, b_inj[i*DATA_W +: DATA_W]});
                end
            end
            assign a_h[i][0] = a_sr_q[i*DATA_W-1 -: DATA_W];
            assign b_v[0][i] = b_sr_q[i*DATA_W-1 -: DATA_W];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DATA_W-1:0] a_fwd, b_fwd;
            systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .a_in  (a_h[i][j]),
                .b_in  (b_v[i][j]),
                .a_out (a_fwd),
                .b_out (b_fwd),
                .acc   (acc_w[i][j])
            );
            if (j < N-1) begin : g_ar
                assign a_h[i][j+1] = a_fwd;
            end else begin : g_ae
                assign a_edge_unused[i] = a_fwd;
            end
            if (i < N-1) begin : g_bd
                assign b_v[i+1][j] = b_fwd;
            end else begin : g_be
                assign b_edge_unused[j] = b_fwd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= LOAD;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (cnt_q == CNT_W'(N-1)) begin
                            state_q <= FLUSH;
                            cnt_q   <= '0;
                            ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                // 2N-1 cycles: the last term reaches PE(N-1,N-1) 2N-2 edges after the final beat.
                FLUSH: begin
                    if (cnt_q == CNT_W'(2*N-2)) begin
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                        row_q   <= '0;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (row_q == RW'(N-1)) begin
                            state_q <= IDLE;
                            row_q   <= '0;
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_out
        assign c_row_out[j*ACC_W +: ACC_W] = valid_q ? acc_w[row_q][j] : '0;
    end

    assign ready_out = ready_q;
    assign valid_out = valid_q;
    assign row_idx   = row_q;
    assign busy      = (state_q != IDLE);
    assign state_o   = state_q;

endmodule

// File: tb/tb_param_systolic_array.sv
// Scoreboard bench: an unsigned and a signed array share stimulus; expected rows are
// queued by the driver and popped by a negedge monitor as each row is offered.
module tb_param_systolic_array;
    import systolic_pkg::*;

    localparam int N      = 3;
    localparam int DATA_W = 4;
    localparam int ACC_W  = 10;
    localparam int RW     = 2;
    localparam int W      = RW + N*ACC_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N*DATA_W-1:0] a_col_in = '0, b_row_in = '0;
    logic                valid_in = 1'b0, out_ready = 1'b1;

    logic                ready_u, valid_u, busy_u, ready_s, valid_s, busy_s;
    logic [N*ACC_W-1:0]  c_row_u, c_row_s;
    logic [RW-1:0]       row_idx_u, row_idx_s;
    state_t              state_u, state_s;

    logic [W-1:0]        exp_u_q[$];
    logic [W-1:0]        exp_s_q[$];
    logic [N*DATA_W-1:0] ja[N], jb[N];
    int                  checks = 0, failures = 0;

    param_systolic_array #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .a_col_in(a_col_in), .b_row_in(b_row_in),
        .valid_in(valid_in), .ready_out(ready_u), .c_row_out(c_row_u), .row_idx(row_idx_u),
        .valid_out(valid_u), .out_ready(out_ready), .busy(busy_u), .state_o(state_u)
    );

    param_systolic_array #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .a_col_in(a_col_in), .b_row_in(b_row_in),
        .valid_in(valid_in), .ready_out(ready_s), .c_row_out(c_row_s), .row_idx(row_idx_s),
        .valid_out(valid_s), .out_ready(out_ready), .busy(busy_s), .state_o(state_s)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] row_exp(input int r, input int e0, input int e1, input int e2);
        return {RW'(r), ACC_W'(e2), ACC_W'(e1), ACC_W'(e0)};
    endfunction

    task automatic push_identity();
        exp_u_q.push_back(row_exp(0, 1, 2, 3));
        exp_u_q.push_back(row_exp(1, 4, 5, 6));
        exp_u_q.push_back(row_exp(2, 7, 8, 9));
        exp_s_q.push_back(row_exp(0, 1, 2, 3));
        exp_s_q.push_back(row_exp(1, 4, 5, 6));
        exp_s_q.push_back(row_exp(2, 7, -8, -7));
    endtask

    task automatic push_uniform(input int vu, input int vs);
        for (int r = 0; r < N; r++) begin
            exp_u_q.push_back(row_exp(r, vu, vu, vu));
            exp_s_q.push_back(row_exp(r, vs, vs, vs));
        end
    endtask

    task automatic load_identity();
        ja[0] = 12'h001; ja[1] = 12'h010; ja[2] = 12'h100;
        jb[0] = 12'h321; jb[1] = 12'h654; jb[2] = 12'h987;
    endtask

    task automatic load_uniform(input logic [3:0] av, input logic [3:0] bv);
        for (int k = 0; k < N; k++) begin
            ja[k] = {av, av, av};
            jb[k] = {bv, bv, bv};
        end
    endtask

    // Driver: presents ja/jb as N beats; optional 1-2 cycle gaps; measures latency from
    // the cycle presenting beat N-1 to the first cycle with valid_out high.
    task automatic send_job(input bit gaps, input bit timed);
        int lat;
        for (int k = 0; k < N; k++) begin
            if (k > 0) begin
                if (gaps) begin
                    valid_in = 1'b0;
                    repeat ($urandom_range(1, 2)) @(posedge clk);
                    #1;
                end
            end
            a_col_in = ja[k];
            b_row_in = jb[k];
            valid_in = 1'b1;
            if (k < N-1) begin
                @(posedge clk);
                #1;
            end
        end
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            lat++;
            if (lat > 1 && !valid_u) check("ready_flush", W'(ready_u), W'(0));
        end while (!valid_u && lat < 100);
        check("valid_rise", W'(valid_u), W'(1));
        if (timed) check("latency", W'(lat), W'(2*N));
    endtask

    task automatic drain(input bit stall);
        int n;
        if (stall) begin
            for (int r = 0; r < N; r++) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
                @(posedge clk);
                #1;
            end
        end else begin
            n = 0;
            while (busy_u && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        out_ready = 1'b1;
        check("done_busy_u", W'(busy_u), W'(0));
        check("done_busy_s", W'(busy_s), W'(0));
        check("done_ready", W'(ready_u), W'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, W'(valid_u), W'(0));
        check({tag, "_crow"}, W'(c_row_u), W'(0));
        check({tag, "_row"}, W'(row_idx_u), W'(0));
        check({tag, "_busy"}, W'(busy_u), W'(0));
        check({tag, "_ready"}, W'(ready_u), W'(1));
        check({tag, "_state"}, W'(state_u), W'(IDLE));
        check({tag, "_busy_s"}, W'(busy_s), W'(0));
        check({tag, "_crow_s"}, W'(c_row_s), W'(0));
    endtask

    // Monitor: pops on a row transfer, compares against the head while the sink stalls.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_u) begin
                check("ready_drain_u", W'(ready_u), W'(0));
                if (exp_u_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scb_u_extra actual=%h required=none", {row_idx_u, c_row_u});
                end else if (out_ready) begin
                    check("row_u", {row_idx_u, c_row_u}, exp_u_q.pop_front());
                end else begin
                    check("stall_u", {row_idx_u, c_row_u}, exp_u_q[0]);
                end
            end
            if (valid_s) begin
                if (exp_s_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scb_s_extra actual=%h required=none", {row_idx_s, c_row_s});
                end else if (out_ready) begin
                    check("row_s", {row_idx_s, c_row_s}, exp_s_q.pop_front());
                end else begin
                    check("stall_s", {row_idx_s, c_row_s}, exp_s_q[0]);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        check_reset_state("reset_idle");

        load_identity();
        push_identity();
        send_job(1'b0, 1'b1);
        drain(1'b0);

        load_uniform(4'hF, 4'hF);
        push_uniform(675, 3);
        send_job(1'b0, 1'b1);
        drain(1'b0);

        load_uniform(4'h8, 4'h8);
        push_uniform(192, 192);
        send_job(1'b0, 1'b1);
        drain(1'b0);

        load_uniform(4'hF, 4'h1);
        push_uniform(45, -3);
        send_job(1'b0, 1'b1);
        drain(1'b0);

        out_ready = 1'b0;
        load_identity();
        push_identity();
        send_job(1'b1, 1'b0);
        drain(1'b1);

        // Reset in the middle of FLUSH; nothing is queued for this job.
        load_uniform(4'hF, 4'hF);
        for (int k = 0; k < N; k++) begin
            a_col_in = ja[k];
            b_row_in = jb[k];
            valid_in = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("mid_flush_state", W'(state_u), W'(FLUSH));
        check("mid_flush_busy", W'(busy_u), W'(1));
        check("mid_flush_ready", W'(ready_u), W'(0));
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        load_identity();
        push_identity();
        send_job(1'b0, 1'b1);
        drain(1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("scb_u_left", W'(exp_u_q.size()), W'(0));
        check("scb_s_left", W'(exp_s_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
